// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch sequencer for the mini computer's 18-bit
//                instruction ROM. Owns the program counter, issues one ROM
//                read at a time and presents each fetched instruction to the
//                decode stage over a valid/ready handshake. Supports
//                sequential wrap-around fetch, decoder-driven jumps,
//                halt/resume and a saturating retired-instruction counter.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   rising-edge clock
//    rst          in   synchronous active-high reset
//    start        in   leave IDLE/HALTED and begin fetching at current PC
//    halt_req     in   stop after the instruction in flight is consumed
//    mem_en       out  ROM read strobe (one cycle per fetch)
//    mem_addr     out  ROM read address, holds last issued address
//    mem_data     in   ROM read data, valid the cycle after mem_en
//    instr_valid  out  instr/instr_pc hold a fetched instruction
//    instr_ready  in   decoder accepts the instruction this cycle
//    instr        out  fetched instruction
//    instr_pc     out  address the instruction was fetched from
//    jmp_valid    in   redirect, sampled only on a handshake
//    jmp_addr     in   redirect target
//    running      out  fetch in progress
//    halted       out  stopped after a halt request
//    retired      out  completed handshakes, saturating at all-ones
// ============================================================================
module fetch_sequencer #(
    parameter int ADDR_W     = 3,
    parameter int INSTR_W    = 18,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt_req,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               jmp_valid,
    input  logic [ADDR_W-1:0]  jmp_addr,
    output logic               running,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] C_START_PC = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] C_PC_ONE   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t               state_q;
    logic [ADDR_W-1:0]    pc_q;
    logic                 halt_pend_q;
    logic                 mem_en_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic                 instr_valid_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [ADDR_W-1:0]    instr_pc_q;
    logic                 running_q;
    logic                 halted_q;
    logic [CNT_W-1:0]     retired_q;

    // Next-value helpers
    logic [ADDR_W-1:0]    pc_d;
    logic [CNT_W-1:0]     retired_d;
    logic                 handshake;
    logic                 stop_after;

    // instr_valid_q is only ever set while in HOLD, so this is the HOLD-state
    // handshake without needing a state compare.
    assign handshake  = instr_valid_q & instr_ready;

    // A halt request seen on the handshake cycle itself counts as well.
    assign stop_after = halt_pend_q | halt_req;

    always_comb begin
        // The add is ADDR_W bits wide, so the last ROM address rolls to 0.
        pc_d      = jmp_valid ? jmp_addr : (pc_q + C_PC_ONE);
        retired_d = (&retired_q) ? retired_q : (retired_q + C_CNT_ONE);
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= C_START_PC;
            halt_pend_q   <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= C_START_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
            retired_q     <= '0;
        end else begin
            case (state_q)
                // Idle and halted both wait for start; a simultaneous
                // halt_req is simply not looked at here.
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_q    <= S_ISSUE;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= pc_q;
                        running_q  <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end

                // Read strobe was raised on entry; drop it after one cycle.
                S_ISSUE: begin
                    mem_en_q <= 1'b0;
                    state_q  <= S_WAIT;
                    if (halt_req) begin
                        halt_pend_q <= 1'b1;
                    end
                end

                // ROM data for the issued address is on mem_data now.
                S_WAIT: begin
                    instr_q       <= mem_data;
                    instr_pc_q    <= pc_q;
                    instr_valid_q <= 1'b1;
                    state_q       <= S_HOLD;
                    if (halt_req) begin
                        halt_pend_q <= 1'b1;
                    end
                end

                // Present the instruction until the decoder takes it.
                S_HOLD: begin
                    if (handshake) begin
                        retired_q     <= retired_d;
                        pc_q          <= pc_d;
                        instr_valid_q <= 1'b0;
                        if (stop_after) begin
                            state_q     <= S_HALTED;
                            halt_pend_q <= 1'b0;
                            running_q   <= 1'b0;
                            halted_q    <= 1'b1;
                        end else begin
                            // Issue the next fetch straight from the new PC.
                            state_q    <= S_ISSUE;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= pc_d;
                        end
                    end else if (halt_req) begin
                        halt_pend_q <= 1'b1;
                    end
                end

                default: begin
                    state_q       <= S_IDLE;
                    mem_en_q      <= 1'b0;
                    instr_valid_q <= 1'b0;
                    running_q     <= 1'b0;
                    halted_q      <= 1'b0;
                    halt_pend_q   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign mem_en      = mem_en_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule
`default_nettype wire
